// File: rtl/priority_encoder.sv
// priority_encoder: picks the highest-priority set bit of 'bits' and reports
// it both as a binary index and as a one-hot vector. LSB_HIGH_PRIORITY
// selects whether bit 0 or bit WIDTH-1 wins.
module priority_encoder #(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0,
    localparam int ENC_W            = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] bits,
    output logic             valid,
    output logic [ENC_W-1:0] encoded,
    output logic [WIDTH-1:0] unencoded
);

    // Scan from the lowest-priority end so the last hit is the winner
    always_comb begin
        valid     = |bits;
        encoded   = '0;
        unencoded = '0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (bits[i]) begin
                    encoded      = ENC_W'(i);
                    unencoded    = '0;
                    unencoded[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (bits[i]) begin
                    encoded      = ENC_W'(i);
                    unencoded    = '0;
                    unencoded[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// port_arbiter: N-way request arbiter with registered one-hot grant,
// grant-valid flag and encoded grant index. Fixed priority or round robin,
// with optional grant holding (until request drops or until acknowledge).
// Define PORT_ARBITER_ASSERT_EN to compile in grant consistency assertions.
module port_arbiter #(
    parameter int PORTS                 = 4,
    parameter int ARB_TYPE_ROUND_ROBIN  = 0,
    parameter int ARB_BLOCK             = 0,
    parameter int ARB_BLOCK_ACK         = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = 0,
    localparam int ENC_W                = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] acknowledge,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic [ENC_W-1:0] grant_encoded
);

    localparam bit              ROUND_ROBIN = (ARB_TYPE_ROUND_ROBIN != 0);
    localparam bit              BLOCK       = (ARB_BLOCK != 0);
    localparam bit              BLOCK_ACK   = (ARB_BLOCK_ACK != 0);
    localparam bit              LSB_HIGH    = (ARB_LSB_HIGH_PRIORITY != 0);
    localparam logic [PORTS-1:0] ALL_ONES   = '1;

    logic [PORTS-1:0] mask;
    logic [PORTS-1:0] next_mask;
    logic [PORTS-1:0] masked_request;

    logic             req_valid;
    logic [ENC_W-1:0] req_enc;
    logic [PORTS-1:0] req_onehot;

    logic             masked_valid;
    logic [ENC_W-1:0] masked_enc;
    logic [PORTS-1:0] masked_onehot;

    logic [ENC_W-1:0] win_enc;
    logic [PORTS-1:0] win_onehot;

    logic             hold_on_request;
    logic             hold_on_ack;

    assign masked_request = request & mask;

    priority_encoder #(
        .WIDTH            (PORTS),
        .LSB_HIGH_PRIORITY(ARB_LSB_HIGH_PRIORITY)
    ) u_req_encoder (
        .bits     (request),
        .valid    (req_valid),
        .encoded  (req_enc),
        .unencoded(req_onehot)
    );

    priority_encoder #(
        .WIDTH            (PORTS),
        .LSB_HIGH_PRIORITY(ARB_LSB_HIGH_PRIORITY)
    ) u_masked_encoder (
        .bits     (masked_request),
        .valid    (masked_valid),
        .encoded  (masked_enc),
        .unencoded(masked_onehot)
    );

    // Round robin prefers ports past the last winner; otherwise plain priority
    always_comb begin
        win_enc    = req_enc;
        win_onehot = req_onehot;
        if (ROUND_ROBIN && masked_valid) begin
            win_enc    = masked_enc;
            win_onehot = masked_onehot;
        end
    end

    // Mask for the next round: only ports after the winner in priority order
    always_comb begin
        if (LSB_HIGH) begin
            next_mask = ALL_ONES << (int'(win_enc) + 1);
        end else begin
            next_mask = ALL_ONES >> (PORTS - int'(win_enc));
        end
    end

    // Conditions under which the current owner keeps the grant
    always_comb begin
        hold_on_request = BLOCK && !BLOCK_ACK && (|(grant & request));
        hold_on_ack     = BLOCK && BLOCK_ACK && grant_valid && !(|(grant & acknowledge));
    end

    // Grant state and round-robin mask; holding or idle leave the mask alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
            mask          <= '0;
        end else if (hold_on_request || hold_on_ack) begin
            grant         <= grant;
            grant_valid   <= grant_valid;
            grant_encoded <= grant_encoded;
        end else if (req_valid) begin
            grant         <= win_onehot;
            grant_valid   <= 1'b1;
            grant_encoded <= win_enc;
            if (ROUND_ROBIN) begin
                mask <= next_mask;
            end
        end else begin
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
        end
    end

`ifdef PORT_ARBITER_ASSERT_EN
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant));
    a_grant_valid : assert property (@(posedge clk) disable iff (rst)
        grant_valid == (|grant));
    a_grant_index : assert property (@(posedge clk) disable iff (rst)
        grant_valid |-> grant[grant_encoded]);
`else
    // Checks compiled out; the datapath above is unchanged.
`endif

endmodule

// File: tb/tb_port_arbiter.sv
// tb_port_arbiter: drives four arbiter configurations side by side from a
// shared clock/reset and compares every output each cycle against a
// behavioural model that tracks "current owner" and "last winner" as plain
// port indices. Directed phases first, then randomized requests/acks.
module tb_port_arbiter;

    localparam int NDUT = 4;
    // d0: fixed, LSB high, no hold   d1: fixed, MSB high, no hold
    // d2: round robin, LSB high, hold until ack
    // d3: round robin, MSB high, hold while requesting
    localparam int CFG_RR    [NDUT] = '{0, 0, 1, 1};
    localparam int CFG_BLOCK [NDUT] = '{0, 0, 1, 1};
    localparam int CFG_ACK   [NDUT] = '{1, 1, 1, 0};
    localparam int CFG_LSB   [NDUT] = '{1, 0, 1, 0};

    logic       clk;
    logic       rst;
    logic [3:0] req   [NDUT];
    logic [3:0] ack   [NDUT];
    logic [3:0] grant [NDUT];
    logic       gv    [NDUT];
    logic [1:0] enc   [NDUT];

    int cur  [NDUT];
    int last [NDUT];

    int vectors;
    int miscompares;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        port_arbiter #(
            .PORTS                (4),
            .ARB_TYPE_ROUND_ROBIN (CFG_RR[g]),
            .ARB_BLOCK            (CFG_BLOCK[g]),
            .ARB_BLOCK_ACK        (CFG_ACK[g]),
            .ARB_LSB_HIGH_PRIORITY(CFG_LSB[g])
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .request      (req[g]),
            .acknowledge  (ack[g]),
            .grant        (grant[g]),
            .grant_valid  (gv[g]),
            .grant_encoded(enc[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input int unsigned observed,
                               input int unsigned expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Winner among requesters; round robin first looks past the last winner
    function automatic int pick(input logic [3:0] r, input int rr, input int lsb,
                                input int lastWin);
        if (rr != 0 && lastWin >= 0) begin
            if (lsb != 0) begin
                for (int i = lastWin + 1; i < 4; i++) if (r[i]) return i;
            end else begin
                for (int i = lastWin - 1; i >= 0; i--) if (r[i]) return i;
            end
        end
        if (lsb != 0) begin
            for (int i = 0; i < 4; i++) if (r[i]) return i;
        end else begin
            for (int i = 3; i >= 0; i--) if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic modelStep(input int k);
        bit hold;
        int w;
        hold = 1'b0;
        if (CFG_BLOCK[k] != 0 && CFG_ACK[k] == 0 && cur[k] >= 0 && req[k][cur[k]])
            hold = 1'b1;
        if (CFG_BLOCK[k] != 0 && CFG_ACK[k] != 0 && cur[k] >= 0 && !ack[k][cur[k]])
            hold = 1'b1;
        if (!hold) begin
            w = pick(req[k], CFG_RR[k], CFG_LSB[k], last[k]);
            cur[k] = w;
            if (w >= 0) last[k] = w;
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < NDUT; k++) begin
            cur[k]  = -1;
            last[k] = -1;
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("d%0d grant", k), grant[k],
                        (cur[k] >= 0) ? (32'd1 << cur[k]) : 0);
            checkOutput($sformatf("d%0d grant_valid", k), gv[k], (cur[k] >= 0) ? 1 : 0);
            checkOutput($sformatf("d%0d grant_encoded", k), enc[k],
                        (cur[k] >= 0) ? cur[k] : 0);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model and compare
    task automatic applyStimulus(input logic [3:0] r0, r1, r2, r3,
                                 input logic [3:0] a0, a1, a2, a3);
        req[0] = r0; req[1] = r1; req[2] = r2; req[3] = r3;
        ack[0] = a0; ack[1] = a1; ack[2] = a2; ack[3] = a3;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) modelStep(k);
        checkAll();
    endtask

    initial begin
        int seq [4];
        logic [3:0] a2;
        vectors     = 0;
        miscompares = 0;
        seq         = '{1, 2, 3, 0};
        for (int k = 0; k < NDUT; k++) begin
            req[k] = '0;
            ack[k] = '0;
        end
        modelReset();

        rst = 1'b1;
        #1;
        checkAll();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed: priority, holding and handoff");
        applyStimulus(4'b1010, 4'b0111, 4'b0100, 4'b0011, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("fixed lsb grant", grant[0], 4'b0010);
        checkOutput("fixed lsb enc", enc[0], 1);
        checkOutput("fixed msb grant", grant[1], 4'b0100);
        checkOutput("fixed msb enc", enc[1], 2);
        checkOutput("rr ack first grant", grant[2], 4'b0100);
        checkOutput("rr req first grant", grant[3], 4'b0010);

        applyStimulus(4'b0000, 4'b0111, 4'b0001, 4'b0011, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("fixed lsb idle grant", grant[0], 0);
        checkOutput("fixed lsb idle valid", gv[0], 0);
        checkOutput("hold without ack", grant[2], 4'b0100);
        checkOutput("hold while requested", grant[3], 4'b0010);

        applyStimulus(4'b0000, 4'b0111, 4'b0001, 4'b0001, 4'h0, 4'h0, 4'b0100, 4'h0);
        checkOutput("release on ack", grant[2], 4'b0001);
        checkOutput("release on drop", grant[3], 4'b0001);

        $display("[TB] directed: round robin handoff on acknowledge");
        for (int n = 0; n < 4; n++) begin
            a2 = (cur[2] >= 0) ? 4'(1 << cur[2]) : 4'h0;
            applyStimulus(4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'h0, 4'h0, a2, 4'h0);
            checkOutput($sformatf("rr sequence step %0d", n), enc[2], seq[n]);
            checkOutput($sformatf("rr no gap step %0d", n), gv[2], 1);
        end

        $display("[TB] directed: asynchronous reset mid-grant");
        applyStimulus(4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("pre-reset grant", grant[1], 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("rr after reset", grant[2], 4'b0001);
        checkOutput("rr msb after reset", grant[3], 4'b1000);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom & $urandom), 4'($urandom & $urandom),
                          4'($urandom & $urandom), 4'($urandom & $urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
